// File: rtl/inst_assemble.sv
// ---------------------------------------------------------------------------
// inst_assemble
//
// Field-level RISC-V instruction encoder. Takes decoded instruction fields
// plus a format tag, packs them into a 32-bit RV64I encoding, and range-checks
// the immediate. Each legal instruction gets a sequential PC. The instruction
// and its PC are then buffered in a small FIFO that drains to an
// instruction-memory writer.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            synchronous clear of the FIFO, PC counter and error pulse
//   in_valid/ready   request handshake (in_ready = FIFO not full)
//   in_fmt           0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2
//                    raw instruction fields, ignored where a format lacks them
//   in_imm           signed byte-offset immediate (U: final value, low 12 = 0)
//   out_valid/ready  FIFO head handshake
//   out_inst         encoded instruction at the head (0 when empty)
//   out_addr         PC of the head instruction (0 when empty)
//   err_valid        one-cycle pulse after an accepted illegal request
//   err_code         0=illegal fmt, 1=imm out of range, 2=imm misaligned
//   count            FIFO occupancy
// ---------------------------------------------------------------------------
module inst_assemble #(
    parameter int          DEPTH     = 4,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_fmt,
    input  logic [6:0]               in_opcode,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [31:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [63:0]              out_addr,
    output logic                     err_valid,
    output logic [1:0]               err_code,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_FMT   = 2'd0;
    localparam logic [1:0] ERR_RANGE = 2'd1;
    localparam logic [1:0] ERR_ALIGN = 2'd2;

    logic [31:0]   mem_inst [DEPTH];
    logic [63:0]   mem_addr [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [63:0]   pc;

    logic [31:0]   enc;
    logic          chk_err;
    logic [1:0]    chk_code;
    logic          accept;
    logic          push;
    logic          pop;
    logic          clear;

    // Handshake qualifiers. Readiness depends only on occupancy, so a full
    // FIFO refuses a request even if the head is being popped this cycle.
    // An accepted request with a bad immediate or format still completes the
    // handshake but never reaches the FIFO.
    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && !chk_err;
    assign pop       = out_valid && out_ready;
    assign clear     = rst || flush;

    // Head of the FIFO is presented directly; outputs are forced to zero
    // while empty so stale entries are never visible.
    assign out_inst = out_valid ? mem_inst[rd_ptr] : 32'd0;
    assign out_addr = out_valid ? mem_addr[rd_ptr] : 64'd0;

    // Pack the fields into the 32-bit encoding for the requested format.
    // B and J immediates are byte offsets whose bit 0 is implied, so their
    // bit scrambles start at imm[1].
    always_comb begin
        enc = 32'd0;
        case (in_fmt)
            FMT_R: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:0], in_opcode};
            FMT_B: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: enc = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                          in_rd, in_opcode};
            default: enc = 32'd0;
        endcase
    end

    // Immediate legality. An illegal format wins over everything; for B/J a
    // misaligned offset is reported before an out-of-range one. Range checks
    // ask whether the upper bits are a pure sign extension of the field.
    always_comb begin
        chk_err  = 1'b0;
        chk_code = ERR_FMT;
        case (in_fmt)
            FMT_R: begin
                chk_err = 1'b0;
            end
            FMT_I, FMT_S: begin
                if (in_imm[31:11] != {21{in_imm[11]}}) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_RANGE;
                end
            end
            FMT_B: begin
                if (in_imm[0]) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_ALIGN;
                end else if (in_imm[31:12] != {20{in_imm[12]}}) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_RANGE;
                end
            end
            FMT_U: begin
                if (in_imm[11:0] != 12'd0) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_RANGE;
                end
            end
            FMT_J: begin
                if (in_imm[0]) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_ALIGN;
                end else if (in_imm[31:20] != {12{in_imm[20]}}) begin
                    chk_err  = 1'b1;
                    chk_code = ERR_RANGE;
                end
            end
            default: begin
                chk_err  = 1'b1;
                chk_code = ERR_FMT;
            end
        endcase
    end

    // Control state: pointers, occupancy, PC counter and the error pulse.
    // Flush behaves like reset and also swallows any same-cycle push/pop.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pc        <= BASE_ADDR;
            err_valid <= 1'b0;
            err_code  <= ERR_FMT;
        end else begin
            err_valid <= accept && chk_err;
            if (accept && chk_err) begin
                err_code <= chk_code;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                pc     <= pc + 64'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array. Kept out of the reset path since entries are only ever
    // read while the occupancy says they are valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_inst[wr_ptr] <= enc;
            mem_addr[wr_ptr] <= pc;
        end
    end

endmodule

// File: doc/inst_assemble.md
Name: inst_assemble

Overview:
- Field-level RISC-V instruction encoder; the inverse of the core's instruction field split.
- Accepts decoded fields plus a format tag over a valid/ready handshake and packs them into 32-bit RV64I encodings.
- Range-checks immediates, stamps each instruction with a sequential PC, and buffers results in a small FIFO.
- The FIFO drains to an instruction-memory writer. Used by the self-test program loader and by the bench.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, >=2)
- BASE_ADDR, 64'h80000000, address given to the first instruction after reset/flush

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous clear of FIFO and PC counter
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- in_fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- in_opcode  in  7  inst[6:0]
- in_funct3  in  3  inst[14:12] (R/I/S/B)
- in_funct7  in  7  inst[31:25] (R only)
- in_rd  in  5  inst[11:7] (R/I/U/J)
- in_rs1  in  5  inst[19:15] (R/I/S/B)
- in_rs2  in  5  inst[24:20] (R/S/B)
- in_imm  in  32  full signed byte-offset immediate; U-type is the final value with low 12 bits zero
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_inst  out  32  encoded instruction at head
- out_addr  out  64  PC of head instruction
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  0=illegal fmt, 1=imm out of range, 2=imm misaligned
- count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at posedge):
  - out_valid=0, count=0, err_valid=0, err_code=0.
  - PC counter=BASE_ADDR, read/write pointers=0.
  - out_inst and out_addr are driven 0 while the FIFO is empty.
- in_ready = (count != DEPTH). It is combinational from state only and does not depend on out_ready; there is no same-cycle pass-through when full.
- Encoding is combinational from the in_* fields and registered on accept. Unused fields for a format are ignored.
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Checks, in priority order: illegal fmt > misaligned > range.
  - I/S: imm[31:11] all equal (signed 12-bit).
  - B: imm[31:12] all equal; imm[0]=0.
  - J: imm[31:20] all equal; imm[0]=0.
  - U: imm[11:0]=0, otherwise code 1.
  - R: no imm check.
- Accepted legal request:
  - Written to the FIFO with out_addr=PC at posedge; PC += 4.
  - Visible on out_* the next cycle if the FIFO was empty (latency 1).
- Accepted illegal request:
  - Handshake completes but nothing is enqueued and the PC is unchanged.
  - err_valid=1 with err_code for exactly the cycle after the accept; otherwise err_valid=0.
- Pop: out_valid&&out_ready advances the head; out_addr/out_inst update to the next entry in the same posedge.
- Simultaneous push+pop: count unchanged, both pointers advance. Legal whenever in_ready=1.
- Pop when empty and push when full are impossible by handshake; an ignored in_valid leaves state unchanged.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- PC wraps modulo 2^64, no flag.
- flush: same effect as rst on FIFO, PC, and err_valid. It takes priority over a same-cycle push/pop, and that request is dropped (in_ready stays as computed, so the initiator must not rely on that cycle). rst has priority over flush.
- Reset or flush mid-drain discards all entries; the next enqueue gets BASE_ADDR.

Test Plan:
- I-type addi x1,x0,5 (fmt1, op 0x13, f3 0, rd1, rs1 0, imm 5) -> next cycle out_valid=1, out_inst=0x00500093, out_addr=0x80000000.
- S then J back-to-back with out_ready=1:
  - sw x2,8(x1) (op 0x23, f3 2, rs1 1, rs2 2, imm 8) -> 0x0020A423 @0x80000000.
  - jal x1,-4 (op 0x6F, rd1, imm 0xFFFFFFFC) -> 0xFFDFF0EF @0x80000004.
- Errors:
  - B beq with imm=3 -> err_valid one cycle, err_code=2, no enqueue.
  - I with imm=0x800 -> err_code=1.
  - fmt=6 -> err_code=0.
  - Next legal instruction still gets the next unused PC.
- U lui x5,0x12345000 (op 0x37) -> 0x123452B7.
- Full/drain:
  - Push 5 requests with out_ready=0 and DEPTH=4 -> in_ready=0 after the 4th accept, count=4, 5th held.
  - Raise out_ready -> entries emerge in order at 0x80000000..0x8000000C, 5th accepted during drain.
  - Simultaneous push/pop keeps count constant.
- Flush with 3 entries queued and a push pending -> count=0, out_valid=0 next cycle, pending push dropped; next push gets addr 0x80000000. Same check repeated with rst.
